// File: rtl/lfsr_checker.sv
// PRBS receive checker: seeds from the incoming LFSR word stream, locks after a run of
// correct predictions, then free-runs its own prediction and counts mismatched words.
module lfsr_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     taps,
    input  logic [WIDTH-1:0]     data,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] word_count
);

    typedef enum logic [1:0] {SEEK, SYNC, LOCKD} state_t;

    localparam logic [7:0] LOCK_C = 8'(LOCK_COUNT);
    localparam logic [7:0] LOSS_C = 8'(LOSS_COUNT);

    state_t                r_state;
    state_t                w_next_state;
    logic [WIDTH-1:0]      r_pred;
    logic [7:0]            r_run;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_err_count;
    logic [CNT_WIDTH-1:0]  r_word_count;

    logic [WIDTH-1:0]      w_nxt_data;
    logic [WIDTH-1:0]      w_nxt_pred;
    logic                  w_match;
    logic                  w_data_nz;
    logic [7:0]            w_run_inc;
    logic                  w_chk;

    assign w_nxt_data = {data[WIDTH-2:0], ^(data & taps)};
    assign w_nxt_pred = {r_pred[WIDTH-2:0], ^(r_pred & taps)};
    assign w_match    = (data == r_pred);
    assign w_data_nz  = |data;
    assign w_run_inc  = r_run + 8'd1;
    assign w_chk      = enable && (r_state == LOCKD);

    always_ff @(posedge clk) begin
        if (rst) r_state <= SEEK;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (enable) begin
            case (r_state)
                SEEK:    if (w_data_nz) w_next_state = SYNC;
                SYNC: begin
                    if (w_match) begin
                        if (w_run_inc == LOCK_C) w_next_state = LOCKD;
                    end else if (!w_data_nz) begin
                        w_next_state = SEEK;
                    end
                end
                LOCKD:   if (!w_match && w_run_inc == LOSS_C) w_next_state = SEEK;
                default: w_next_state = SEEK;
            endcase
        end
    end

    always_comb begin
        locked = (r_state == LOCKD);
    end

    // Once locked the prediction never re-seeds from data, so corrupt words cannot pull it off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred <= '0;
            r_run  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (enable) begin
                case (r_state)
                    SEEK: begin
                        if (w_data_nz) begin
                            r_pred <= w_nxt_data;
                            r_run  <= '0;
                        end
                    end
                    SYNC: begin
                        if (w_match) begin
                            r_pred <= w_nxt_data;
                            r_run  <= (w_run_inc == LOCK_C) ? 8'd0 : w_run_inc;
                        end else begin
                            if (w_data_nz) r_pred <= w_nxt_data;
                            r_run <= '0;
                        end
                    end
                    LOCKD: begin
                        r_pred <= w_nxt_pred;
                        r_err  <= !w_match;
                        if (w_match)                 r_run <= '0;
                        else if (w_run_inc == LOSS_C) r_run <= '0;
                        else                         r_run <= w_run_inc;
                    end
                    default: r_run <= '0;
                endcase
            end
        end
    end

    // clear wins over a same-edge increment.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_err_count  <= '0;
            r_word_count <= '0;
        end else if (w_chk) begin
            if (r_word_count != '1)             r_word_count <= r_word_count + 1'b1;
            if (!w_match && r_err_count != '1)  r_err_count  <= r_err_count + 1'b1;
        end
    end

    assign err        = r_err;
    assign err_count  = r_err_count;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: reference Fibonacci LFSR stream with injected corruption.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  taps = 8'h8E;
    logic [7:0]  data = 8'h00;
    logic        locked, err, locked2, err2;
    logic [15:0] ec, wc;
    logic [3:0]  ec2, wc2;
    logic [7:0]  g;
    int          n_chk = 0;
    int          n_err = 0;

    lfsr_checker #(.WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .taps(taps), .data(data), .clear(clear),
        .locked(locked), .err(err), .err_count(ec), .word_count(wc));

    lfsr_checker #(.WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(255), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .taps(taps), .data(data), .clear(clear),
        .locked(locked2), .err(err2), .err_count(ec2), .word_count(wc2));

    always #5 clk = ~clk;

    function automatic logic [7:0] nxt(input logic [7:0] s);
        return {s[6:0], ^(s & 8'h8E)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; clear = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic send(input logic corrupt);
        enable = 1'b1;
        data   = corrupt ? (g ^ 8'h01) : g;
        g      = nxt(g);
        step();
        enable = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        int pulses;

        // reset state, then an all-zero stream must never leave SEEK
        do_reset();
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ec", 32'(ec), 0);
        chk("rst_wc", 32'(wc), 0);
        for (int i = 0; i < 6; i++) begin
            enable = 1'b1; data = 8'h00;
            step();
        end
        enable = 1'b0;
        chk("zero_locked", 32'(locked), 0);
        chk("zero_err", 32'(err), 0);

        // lock after seed + 4 matches
        g = 8'h01;
        for (int i = 0; i < 4; i++) send(1'b0);
        chk("s1_not_yet", 32'(locked), 0);
        send(1'b0);
        chk("s1_locked", 32'(locked), 1);
        chk("s1_ec", 32'(ec), 0);
        chk("s1_wc", 32'(wc), 0);

        // long clean run, then a single corrupt word
        pulses = 0;
        for (int i = 0; i < 255; i++) begin
            send(1'b0);
            pulses += int'(err);
        end
        chk("s2_clean_pulses", 32'(pulses), 0);
        chk("s2_wc", 32'(wc), 255);
        send(1'b1);
        chk("s2_err", 32'(err), 1);
        chk("s2_ec", 32'(ec), 1);
        chk("s2_locked", 32'(locked), 1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            send(1'b0);
            pulses += int'(err);
        end
        chk("s2_after_pulses", 32'(pulses), 0);
        chk("s2_locked2", 32'(locked), 1);

        // 4 consecutive corrupt words drop lock, clean stream relocks
        pulse_clear();
        chk("s3_clear_ec", 32'(ec), 0);
        chk("s3_clear_wc", 32'(wc), 0);
        for (int i = 0; i < 3; i++) begin
            send(1'b1);
            chk("s3_err", 32'(err), 1);
        end
        chk("s3_still_locked", 32'(locked), 1);
        send(1'b1);
        chk("s3_err4", 32'(err), 1);
        chk("s3_ec", 32'(ec), 4);
        chk("s3_unlocked", 32'(locked), 0);
        for (int i = 0; i < 4; i++) send(1'b0);
        chk("s3_relock_early", 32'(locked), 0);
        send(1'b0);
        chk("s3_relocked", 32'(locked), 1);
        chk("s3_ec_hold", 32'(ec), 4);
        chk("s3_wc_hold", 32'(wc), 4);

        // enable low holds everything, prediction included
        for (int i = 0; i < 10; i++) begin
            enable = 1'b0; data = 8'hA5;
            step();
        end
        chk("s4_locked", 32'(locked), 1);
        chk("s4_err", 32'(err), 0);
        chk("s4_ec", 32'(ec), 4);
        chk("s4_wc", 32'(wc), 4);
        send(1'b0);
        chk("s4_resume_err", 32'(err), 0);
        chk("s4_resume_wc", 32'(wc), 5);

        // isolated errors don't drop lock; reset while locked clears everything
        pulse_clear();
        send(1'b1); send(1'b0); send(1'b1); send(1'b0); send(1'b1);
        chk("s6_ec", 32'(ec), 3);
        chk("s6_wc", 32'(wc), 5);
        chk("s6_locked", 32'(locked), 1);
        chk("s6_err", 32'(err), 1);
        do_reset();
        chk("s6_rst_locked", 32'(locked), 0);
        chk("s6_rst_err", 32'(err), 0);
        chk("s6_rst_ec", 32'(ec), 0);
        chk("s6_rst_wc", 32'(wc), 0);
        for (int i = 0; i < 4; i++) send(1'b0);
        chk("s6_relock_early", 32'(locked), 0);
        send(1'b0);
        chk("s6_relocked", 32'(locked), 1);

        // a corrupt word during SYNC forces a reseed and is not counted
        do_reset();
        send(1'b0); send(1'b0); send(1'b0);
        send(1'b1);
        for (int i = 0; i < 4; i++) send(1'b0);
        chk("sync_reseed_early", 32'(locked), 0);
        send(1'b0);
        chk("sync_reseed_locked", 32'(locked), 1);
        chk("sync_reseed_ec", 32'(ec), 0);

        // 4-bit counters saturate; clear beats a coincident error
        do_reset();
        for (int i = 0; i < 5; i++) send(1'b0);
        chk("s5_locked", 32'(locked2), 1);
        for (int i = 0; i < 20; i++) send(1'b1);
        chk("s5_ec_sat", 32'(ec2), 32'hF);
        chk("s5_wc_sat", 32'(wc2), 32'hF);
        chk("s5_still_locked", 32'(locked2), 1);
        clear = 1'b1;
        send(1'b1);
        clear = 1'b0;
        chk("s5_clear_ec", 32'(ec2), 0);
        chk("s5_clear_err", 32'(err2), 1);
        send(1'b1);
        chk("s5_after_clear_ec", 32'(ec2), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
